// File: rtl/rca_seq_adder.sv
// Nibble-serial adder: one shared 4-bit ripple-carry cell, LSB nibble first, carry chained via a register.
// Optional subtract mode (sub port, A + ~B + 1) is enabled by defining RCA_SEQ_SUB_EN.

module rca4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       Cin,
    output logic [3:0] sum,
    output logic       carry
);
    logic [4:0] c;
    assign c[0] = Cin;
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign carry = c[4];
endmodule

module rca_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
`ifdef RCA_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout,
    output logic             ovf
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = $clog2(NIB);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, cout_q, ovf_q;

    logic [3:0]       nib_sum;
    logic             nib_carry;
    logic [WIDTH-1:0] b_eff_d;
    logic             carry_init_d;

    rca4 u_rca (
        .a     (a_q[4*cnt_q +: 4]),
        .b     (b_q[4*cnt_q +: 4]),
        .Cin   (carry_q),
        .sum   (nib_sum),
        .carry (nib_carry)
    );

    // Subtract is A + ~B with the initial carry forced to 1; cin is ignored then.
    always_comb begin
        b_eff_d      = b_in;
        carry_init_d = cin;
`ifdef RCA_SEQ_SUB_EN
        if (sub) begin
            b_eff_d      = ~b_in;
            carry_init_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        a_q     <= a_in;
                        b_q     <= b_eff_d;
                        carry_q <= carry_init_d;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[4*cnt_q +: 4] <= nib_sum;
                    carry_q             <= nib_carry;
                    cnt_q               <= cnt_q + CW'(1);
                    if (cnt_q == CW'(NIB - 1)) begin
                        cout_q  <= nib_carry;
                        ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) & (nib_sum[3] != a_q[WIDTH-1]);
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q == RUN);
    assign res_valid   = (state_q == DONE);
    assign sum_out     = sum_q;
    assign cout        = cout_q;
    assign ovf         = ovf_q;
endmodule
